// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-direction traffic-light sequencer.
// Lamp-to-VGA encodings plus a constant-function clog2 for sizing.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } state_e;

    localparam logic [2:0] COLOR_RED = 3'b100;
    localparam logic [2:0] COLOR_YEL = 3'b110;
    localparam logic [2:0] COLOR_GRN = 3'b010;
    localparam logic [2:0] COLOR_OFF = 3'b000;

    localparam logic [2:0] SQ_RED = 3'b001;
    localparam logic [2:0] SQ_YEL = 3'b010;
    localparam logic [2:0] SQ_GRN = 3'b100;
    localparam logic [2:0] SQ_OFF = 3'b000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_tick_sync.sv
// Two-flop synchroniser for the slow timing strobe plus a rising-edge detector.
// tick_o is high for exactly one clk cycle per strobe rise.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    output logic tick_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= strobe_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational edge so the FSM update lands on the third clock after the rise.
    assign tick_o = sync_q & ~prev_q;

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-direction round-robin traffic-light sequencer with all-red clearance,
// latched pedestrian green extension, flash mode and a direction-0 VGA indicator.
module traffic_light_ctrl_n
    import traffic_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int GREEN_T   = 39,
    parameter int YELLOW_T  = 13,
    parameter int ALLRED_T  = 5,
    parameter int PED_EXT_T = 20,
    parameter int CNT_W     = 8
) (
    input  logic             pixelclk,
    input  logic             rst,
    input  logic             clk_5Hz,
    input  logic             mode_flash,
    input  logic [N_DIR-1:0] ped_req,
    output logic [N_DIR-1:0] lamp_r,
    output logic [N_DIR-1:0] lamp_y,
    output logic [N_DIR-1:0] lamp_g,
    output logic [2:0]       active_dir,
    output logic [N_DIR-1:0] ped_ack,
    output logic [2:0]       color,
    output logic [2:0]       squares
);

    localparam int DIR_W = (clog2(N_DIR) < 1) ? 1 : clog2(N_DIR);
    typedef logic [DIR_W-1:0] dir_t;

    logic             tick;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    dir_t             next_dir;
    logic             ext_q, ext_d;
    logic             flash_y_q, flash_y_d;
    logic [N_DIR-1:0] latch_q, latch_d;
    logic [N_DIR-1:0] ack_q, ack_d;
    logic [2:0]       color_q, color_d;
    logic [2:0]       squares_q, squares_d;
    logic             enter_green;
    logic [CNT_W-1:0] green_last;

    tick_sync u_tick_sync (
        .clk      (pixelclk),
        .rst      (rst),
        .strobe_i (clk_5Hz),
        .tick_o   (tick)
    );

    assign next_dir   = (dir_q == dir_t'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
    assign green_last = ext_q ? CNT_W'(GREEN_T + PED_EXT_T - 1) : CNT_W'(GREEN_T - 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        ext_d       = ext_q;
        flash_y_d   = flash_y_q;
        enter_green = 1'b0;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                ALLRED: begin
                    if (cnt_q == CNT_W'(ALLRED_T - 1)) begin
                        cnt_d = '0;
                        if (mode_flash) begin
                            state_d   = FLASH;
                            flash_y_d = 1'b1;
                        end else begin
                            state_d     = GREEN;
                            dir_d       = next_dir;
                            ext_d       = latch_q[next_dir];
                            enter_green = 1'b1;
                        end
                    end
                end
                GREEN: begin
                    // A flash request cuts green short but always via full yellow and all-red.
                    if (mode_flash || cnt_q == green_last) begin
                        state_d = YELLOW;
                        cnt_d   = '0;
                    end
                end
                YELLOW: begin
                    if (cnt_q == CNT_W'(YELLOW_T - 1)) begin
                        state_d = ALLRED;
                        cnt_d   = '0;
                    end
                end
                FLASH: begin
                    cnt_d = '0;
                    if (!mode_flash) begin
                        state_d = ALLRED;
                    end else begin
                        flash_y_d = ~flash_y_q;
                    end
                end
                default: begin
                    state_d = ALLRED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIR; gi++) begin : g_dir
            logic served_now;
            logic owns;
            assign served_now = enter_green && (next_dir == dir_t'(gi));
            assign owns       = (dir_q == dir_t'(gi));
            // A request arriving in the serving cycle survives for the next round.
            assign latch_d[gi] = ped_req[gi] | (latch_q[gi] & ~served_now);
            assign ack_d[gi]   = served_now & latch_q[gi];

            assign lamp_r[gi] = (state_q == ALLRED) ||
                                ((state_q == GREEN || state_q == YELLOW) && !owns);
            assign lamp_y[gi] = ((state_q == FLASH) && flash_y_q) ||
                                ((state_q == YELLOW) && owns);
            assign lamp_g[gi] = (state_q == GREEN) && owns;
        end
    endgenerate

    always_comb begin
        color_d   = COLOR_OFF;
        squares_d = SQ_OFF;
        if (lamp_r[0]) begin
            color_d   = COLOR_RED;
            squares_d = SQ_RED;
        end else if (lamp_y[0]) begin
            color_d   = COLOR_YEL;
            squares_d = SQ_YEL;
        end else if (lamp_g[0]) begin
            color_d   = COLOR_GRN;
            squares_d = SQ_GRN;
        end
    end

    always_comb begin
        active_dir              = '0;
        active_dir[DIR_W-1:0]   = dir_q;
    end

    assign ped_ack = ack_q;
    assign color   = color_q;
    assign squares = squares_q;

    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            state_q   <= ALLRED;
            cnt_q     <= '0;
            dir_q     <= dir_t'(N_DIR - 1);
            ext_q     <= 1'b0;
            flash_y_q <= 1'b0;
            latch_q   <= '0;
            ack_q     <= '0;
            color_q   <= COLOR_RED;
            squares_q <= SQ_RED;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            ext_q     <= ext_d;
            flash_y_q <= flash_y_d;
            latch_q   <= latch_d;
            ack_q     <= ack_d;
            color_q   <= color_d;
            squares_q <= squares_d;
        end
    end

endmodule
